// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: memory geometry defaults, loader state encoding and opcodes.
package sap_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap_ram16x8.sv
// SAP-1 program/data store: synchronous write, asynchronous read, synchronous full clear.
module sap_ram16x8
    import sap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: every word must read 0 after reset, so the array is cleared in a loop;
    // this makes it a register file rather than a RAM macro without a reset port.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_ram_loader.sv
// Sequential loader for the SAP-1 program RAM; holds the CPU off while loading.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_ram_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              checksum_err,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    ld_state_t         state, next_state;
    logic [ADDR_W-1:0] wr_addr;
    logic              done_q;
    logic              start_load;
    logic              load_xfer;
    logic              final_xfer;

    assign start_load = load_start && (state == ST_IDLE || state == ST_DONE);
    assign load_xfer  = ld_valid && (state == ST_LOAD);
    assign final_xfer = load_xfer && (ld_last || wr_addr == LAST_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (next_state == ST_DONE) && (state != ST_DONE);
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (load_start) next_state = ST_LOAD;
`ifdef LOADER_CHECKSUM_EN
            ST_LOAD:          if (final_xfer) next_state = ST_CHECK;
            ST_CHECK:         if (ld_valid)   next_state = ST_DONE;
`else
            ST_LOAD:          if (final_xfer) next_state = ST_DONE;
`endif
            default:          next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state == ST_LOAD) || (state == ST_CHECK);
        cpu_hold = (state == ST_LOAD) || (state == ST_CHECK);
        ld_done  = done_q;
    end

    // The address stops at the top word: the final transfer there ends the load instead.
    always_ff @(posedge clk) begin
        if (rst || start_load) begin
            wr_addr <= '0;
        end else if (load_xfer && wr_addr != LAST_ADDR) begin
            wr_addr <= wr_addr + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst || start_load) begin
            sum          <= '0;
            checksum_err <= 1'b0;
        end else begin
            if (load_xfer) sum <= sum + ld_data;
            if (state == ST_CHECK && ld_valid && ld_data != sum) checksum_err <= 1'b1;
        end
    end
`else
    assign checksum_err = 1'b0;
`endif

    sap_ram16x8 #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .clr  (rst),
        .we   (load_xfer),
        .waddr(wr_addr),
        .wdata(ld_data),
        .raddr(cpu_addr),
        .rdata(cpu_data)
    );

endmodule
